// File: rtl/shot_renderer.sv
// Per-frame shot renderer: walks the shot table, erases each shot's last drawn square
// and redraws it at its current position as a one-pixel-per-cycle VGA plot stream.
module shot_renderer #(
    parameter int         SHOT_COUNT  = 8,
    parameter int         SHOT_SIZE   = 2,
    parameter int         SCREEN_W    = 320,
    parameter int         SCREEN_H    = 240,
    parameter logic [2:0] SHOT_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    localparam int        AW          = (SHOT_COUNT > 1) ? $clog2(SHOT_COUNT) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame_tick,
    output logic [AW-1:0] rd_addr,
    input  logic [24:0]   rd_data,
    output logic [8:0]    vga_x,
    output logic [8:0]    vga_y,
    output logic [2:0]    vga_colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_ERASE,
        ST_DRAW,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int            CW        = 2;
    localparam logic [CW-1:0] LAST_OFF  = CW'(SHOT_SIZE - 1);
    localparam logic [AW-1:0] LAST_SLOT = AW'(SHOT_COUNT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] idx_q;
    logic          cur_valid_q;
    logic [8:0]    cur_x_q;
    logic [8:0]    cur_y_q;
    logic [CW-1:0] dx_q;
    logic [CW-1:0] dy_q;

    logic          shadow_valid_q [SHOT_COUNT];
    logic [8:0]    shadow_x_q     [SHOT_COUNT];
    logic [8:0]    shadow_y_q     [SHOT_COUNT];

    logic          scanning;
    logic          last_pix;
    logic [8:0]    base_x;
    logic [8:0]    base_y;
    logic [9:0]    px;
    logic [9:0]    py;
    logic          on_screen;

    // The direction field of the slot record plays no part in rendering.
    logic          unused_dir;
    assign unused_dir = ^rd_data[5:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking (<=) assignments so all registers
    // update from the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (frame_tick) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (shadow_valid_q[idx_q]) state_d = ST_ERASE;
                else if (rd_data[24])      state_d = ST_DRAW;
                else                       state_d = ST_NEXT;
            end
            ST_ERASE:   if (last_pix) state_d = cur_valid_q ? ST_DRAW : ST_NEXT;
            ST_DRAW:    if (last_pix) state_d = ST_NEXT;
            ST_NEXT:    state_d = (idx_q == LAST_SLOT) ? ST_DONE : ST_FETCH;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and pixel datapath
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        rd_addr  = idx_q;
        scanning = (state_q == ST_ERASE) || (state_q == ST_DRAW);
        last_pix = (dx_q == LAST_OFF) && (dy_q == LAST_OFF);
        if (state_q == ST_ERASE) begin
            base_x = shadow_x_q[idx_q];
            base_y = shadow_y_q[idx_q];
        end else begin
            base_x = cur_x_q;
            base_y = cur_y_q;
        end
        // Ten bits wide so a square hanging off the 9-bit range is still clipped.
        px        = {1'b0, base_x} + {{(10-CW){1'b0}}, dx_q};
        py        = {1'b0, base_y} + {{(10-CW){1'b0}}, dy_q};
        on_screen = (px < 10'(SCREEN_W)) && (py < 10'(SCREEN_H));
    end

    // ------------------------------------------------------------------
    // Slot index, current record and square scan counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            cur_valid_q <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
        end else begin
            if (state_q == ST_IDLE && frame_tick)
                idx_q <= '0;
            else if (state_q == ST_NEXT && idx_q != LAST_SLOT)
                idx_q <= idx_q + AW'(1);

            if (state_q == ST_CAPTURE) begin
                cur_valid_q <= rd_data[24];
                cur_y_q     <= rd_data[23:15];
                cur_x_q     <= rd_data[14:6];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (scanning && !last_pix) begin
            if (dx_q == LAST_OFF) begin
                dx_q <= '0;
                dy_q <= dy_q + CW'(1);
            end else begin
                dx_q <= dx_q + CW'(1);
            end
        end else begin
            dx_q <= '0;
            dy_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Shadow table of last-drawn positions
    // ------------------------------------------------------------------
    // NOTE: only the valid bits are reset; coordinates are never read while their
    // valid bit is clear, so the coordinate storage can stay reset-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SHOT_COUNT; k++) shadow_valid_q[k] <= 1'b0;
        end else if (state_q == ST_DRAW && last_pix) begin
            shadow_valid_q[idx_q] <= 1'b1;
        end else if (state_q == ST_NEXT && !cur_valid_q) begin
            shadow_valid_q[idx_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_DRAW && last_pix) begin
            shadow_x_q[idx_q] <= cur_x_q;
            shadow_y_q[idx_q] <= cur_y_q;
        end
    end

    // ------------------------------------------------------------------
    // Registered plot stream; clipped pixels still take their cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
        end else if (scanning) begin
            vga_x      <= px[8:0];
            vga_y      <= py[8:0];
            vga_colour <= (state_q == ST_ERASE) ? BG_COLOUR : SHOT_COLOUR;
            plot       <= on_screen;
        end else begin
            plot       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shot_renderer.sv
// Self-checking bench for shot_renderer: directed scenarios plus randomized tables,
// all compared against a pass-level reference model of erase/draw/clip behaviour.
module tb_shot_renderer;

    localparam int N   = 8;
    localparam int S   = 2;
    localparam int W   = 320;
    localparam int H   = 240;
    localparam logic [2:0] SHOT = 3'b111;
    localparam logic [2:0] BG   = 3'b000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  rd_addr;
    logic [24:0] rd_data;
    logic [8:0]  vga_x;
    logic [8:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        busy;
    logic        done;

    shot_renderer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Shot table with a one-cycle registered read port.
    logic [24:0] tbl [N];
    always @(posedge clk) rd_data <= tbl[rd_addr];

    typedef struct {
        int         x;
        int         y;
        logic [2:0] c;
    } pix_t;

    // Reference model: what the renderer last drew for each slot.
    bit   m_valid [N];
    int   m_x     [N];
    int   m_y     [N];
    pix_t exp_q [$];
    pix_t got_q [$];
    int   exp_len;

    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [24:0] mk(bit v, int x, int y);
        logic [5:0] dir;
        dir = 6'($urandom);
        return {v, 9'(y), 9'(x), dir};
    endfunction

    task automatic add_square(input int bx, input int by, input logic [2:0] c);
        pix_t p;
        for (int dy = 0; dy < S; dy++)
            for (int dx = 0; dx < S; dx++)
                if (bx + dx < W && by + dy < H) begin
                    p.x = bx + dx;
                    p.y = by + dy;
                    p.c = c;
                    exp_q.push_back(p);
                end
    endtask

    task automatic model_pass();
        exp_q.delete();
        exp_len = 1;
        for (int i = 0; i < N; i++) begin
            exp_len += 3;
            if (m_valid[i]) begin
                exp_len += S * S;
                add_square(m_x[i], m_y[i], BG);
            end
            if (tbl[i][24]) begin
                exp_len += S * S;
                add_square(int'(tbl[i][14:6]), int'(tbl[i][23:15]), SHOT);
                m_valid[i] = 1'b1;
                m_x[i] = int'(tbl[i][14:6]);
                m_y[i] = int'(tbl[i][23:15]);
            end else begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endtask

    // Runs one render pass; with noisy set, extra frame_ticks are issued while busy.
    task automatic run_pass(input string name, input bit noisy);
        int busy_cnt;
        int done_cnt;
        bit finished;
        pix_t p;
        model_pass();
        got_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        finished = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (plot) begin
                p.x = int'(vga_x);
                p.y = int'(vga_y);
                p.c = vga_colour;
                got_q.push_back(p);
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            frame_tick = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        frame_tick = 1'b0;

        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL %s timeout: busy still %0b after 500 cycles, required 0", name, busy);
        end
        vectors++;
        if (busy_cnt !== exp_len) begin
            miscompares++;
            $display("FAIL %s pass_len: got %0d cycles, expected %0d", name, busy_cnt, exp_len);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt);
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s plot_count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i].x !== exp_q[i].x || got_q[i].y !== exp_q[i].y || got_q[i].c !== exp_q[i].c) begin
                miscompares++;
                $display("FAIL %s plot[%0d]: got (%0d,%0d,c=%0d), expected (%0d,%0d,c=%0d)", name, i,
                         got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) tbl[i] = mk(1'b0, 0, 0);
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rd_addr, vga_x, vga_y, vga_colour, plot, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got addr=%0d x=%0d y=%0d c=%0d plot=%0b busy=%0b done=%0b, expected all 0",
                     rd_addr, vga_x, vga_y, vga_colour, plot, busy, done);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%0b plot=%0b, expected 0 0", busy, plot);
        end
    endtask

    task automatic test_all_invalid();
        run_pass("all_invalid", 1'b0);
    endtask

    task automatic test_single_draw();
        tbl[3] = mk(1'b1, 50, 100);
        run_pass("single_draw", 1'b0);
    endtask

    task automatic test_move();
        tbl[3] = mk(1'b1, 52, 100);
        run_pass("move", 1'b0);
    endtask

    task automatic test_clear();
        tbl[3] = mk(1'b0, 52, 100);
        run_pass("clear_erase", 1'b0);
        run_pass("clear_empty", 1'b0);
    endtask

    task automatic test_clip();
        tbl[0] = mk(1'b1, 319, 239);
        run_pass("clip_corner", 1'b0);
        tbl[0] = mk(1'b0, 0, 0);
        tbl[6] = mk(1'b1, 400, 20);
        tbl[7] = mk(1'b1, 10, 239);
        run_pass("clip_edges", 1'b0);
    endtask

    task automatic test_busy_ticks();
        for (int i = 0; i < N; i++)
            tbl[i] = mk(1'($urandom_range(0, 1)), $urandom_range(0, 318), $urandom_range(0, 238));
        run_pass("busy_ticks", 1'b1);
    endtask

    task automatic test_reset_mid_draw();
        bit seen;
        for (int i = 0; i < N; i++) tbl[i] = mk(1'b0, 0, 0);
        tbl[1] = mk(1'b1, 30, 40);
        tbl[5] = mk(1'b1, 200, 150);
        seen = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (plot && vga_colour == SHOT) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL mid_draw_wait: no draw plot within 300 cycles, required one");
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got plot=%0b busy=%0b done=%0b, expected 0 0 0", plot, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        run_pass("post_reset", 1'b0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) != 0)
                    tbl[i] = mk(1'($urandom_range(0, 1)), $urandom_range(0, 325), $urandom_range(0, 245));
            run_pass($sformatf("random_%0d", p), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_all_invalid();
        test_single_draw();
        test_move();
        test_clear();
        test_clip();
        test_busy_ticks();
        test_reset_mid_draw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
